// File: rtl/conv_sequencer.sv
// Sequences a 3x3 valid convolution of a 4x4 image ROM against a 9-tap kernel ROM,
// one multiply-accumulate per cycle, and hands each of the 2x2 results out over valid/ready.
module conv_sequencer #(
    parameter int DATA_W = 4,
    parameter int ACC_W  = 12
) (
    input  logic              CLK,
    input  logic              CLR_N,
    input  logic              start,
    output logic [3:0]        img_addr,
    input  logic [DATA_W-1:0] img_data,
    output logic [3:0]        kern_addr,
    input  logic [DATA_W-1:0] kern_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        out_idx,
    output logic [ACC_W-1:0]  out_pixel,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [3:0]         tap, tap_nxt;
    logic [1:0]         pix, pix_nxt;
    logic [ACC_W-1:0]   acc, acc_nxt;
    logic [1:0]         kr, kc;
    logic [1:0]         row, col;

    // Product is at most 8 bits and nine of them fit ACC_W, so a plain zero-extended add suffices.
    function automatic logic [ACC_W-1:0] mac_add(
        input logic [ACC_W-1:0]  a,
        input logic [DATA_W-1:0] x,
        input logic [DATA_W-1:0] w
    );
        logic [2*DATA_W-1:0] prod;
        prod = x * w;
        return a + ACC_W'(prod);
    endfunction

    always_comb begin
        kr = 2'd2;
        kc = 2'd2;
        case (tap)
            4'd0:    begin kr = 2'd0; kc = 2'd0; end
            4'd1:    begin kr = 2'd0; kc = 2'd1; end
            4'd2:    begin kr = 2'd0; kc = 2'd2; end
            4'd3:    begin kr = 2'd1; kc = 2'd0; end
            4'd4:    begin kr = 2'd1; kc = 2'd1; end
            4'd5:    begin kr = 2'd1; kc = 2'd2; end
            4'd6:    begin kr = 2'd2; kc = 2'd0; end
            4'd7:    begin kr = 2'd2; kc = 2'd1; end
            default: begin kr = 2'd2; kc = 2'd2; end
        endcase
        row = {1'b0, pix[1]} + kr;
        col = {1'b0, pix[0]} + kc;
    end

    // Addresses decode straight off the registered counters, so they hold in OUT/DONE.
    assign img_addr  = {row, col};
    assign kern_addr = tap;
    assign out_valid = (state == OUT);
    assign out_idx   = pix;
    assign out_pixel = acc;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    always_comb begin
        state_nxt = state;
        tap_nxt   = tap;
        pix_nxt   = pix;
        acc_nxt   = acc;
        case (state)
            IDLE: begin
                if (start) begin
                    acc_nxt   = '0;
                    pix_nxt   = 2'd0;
                    tap_nxt   = 4'd0;
                    state_nxt = MAC;
                end
            end
            MAC: begin
                acc_nxt = mac_add(acc, img_data, kern_data);
                if (tap == 4'd8) begin
                    state_nxt = OUT;
                end else begin
                    tap_nxt = tap + 4'd1;
                end
            end
            OUT: begin
                if (out_ready) begin
                    if (pix == 2'd3) begin
                        state_nxt = DONE;
                    end else begin
                        pix_nxt   = pix + 2'd1;
                        tap_nxt   = 4'd0;
                        acc_nxt   = '0;
                        state_nxt = MAC;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state <= IDLE;
            tap   <= 4'd0;
            pix   <= 2'd0;
            acc   <= '0;
        end else begin
            state <= state_nxt;
            tap   <= tap_nxt;
            pix   <= pix_nxt;
            acc   <= acc_nxt;
        end
    end

endmodule

// File: doc/conv_sequencer.md
Name: conv_sequencer

Overview:
- Sequences the 3x3 valid convolution of the 4x4, 4-bit image against the 9-entry, 4-bit kernel coefficient ROM.
- Drives the image-ROM and kernel-ROM address buses and multiply-accumulates the returned data.
- Emits the 2x2 output pixels over a valid/ready handshake.
- Sits between the start/done control of the top level and the image/kernel storage and output buffer.

Parameters:
- DATA_W, 4, width of image pixels and kernel coefficients.
- ACC_W, 12, accumulator/output width; covers 9 x 15 x 15 = 2025.

Ports:
- CLK  input  1  rising-edge clock
- CLR_N  input  1  asynchronous active-low reset
- start  input  1  pulse or level; accepted only in IDLE
- img_addr  output  4  image ROM address, row-major (row*4 + col)
- img_data  input  DATA_W  image ROM data; combinational from img_addr, same cycle
- kern_addr  output  4  kernel ROM address 0..8 (kr*3 + kc)
- kern_data  input  DATA_W  kernel ROM data; combinational from kern_addr, same cycle
- out_valid  output  1  out_pixel/out_idx valid
- out_ready  input  1  consumer accepts pixel when out_valid & out_ready
- out_idx  output  2  output pixel index, orow*2 + ocol
- out_pixel  output  ACC_W  convolution result, unsigned
- busy  output  1  high in any state except IDLE
- done  output  1  one-cycle pulse after last pixel accepted

Behaviour:
- Reset (CLR_N low, asynchronous): state=IDLE; counters and acc = 0; out_valid=0, done=0, busy=0, img_addr=0, kern_addr=0, out_idx=0, out_pixel=0. Reset mid-operation abandons the frame; no partial output or done is produced.
- States: IDLE, MAC, OUT, DONE.
- IDLE:
  - start=1 at a clock edge: clear acc, pix=0, tap=0, go to MAC.
  - start=0: stay in IDLE.
- MAC:
  - Tap counter tap (0..8), split into kr=tap/3 and kc=tap%3.
  - kern_addr = tap; img_addr = (orow+kr)*4 + (ocol+kc), with orow=pix[1], ocol=pix[0].
  - Each cycle: acc <= acc + img_data*kern_data. Product is 8-bit, zero-extended to ACC_W; no saturation needed.
  - tap==8: final add, go to OUT. Exactly 9 cycles per pixel.
- OUT:
  - out_valid=1; out_pixel = acc (registered, stable while in OUT); out_idx = pix.
  - Stay in OUT while out_ready=0; all outputs held.
  - On out_valid & out_ready:
    - pix<3: pix++, tap=0, acc=0, go to MAC.
    - pix==3: go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- busy=1 in MAC, OUT and DONE.
- In OUT and DONE, img_addr and kern_addr hold their last MAC values.
- start while busy is ignored; it is not queued.
- Latency with out_ready tied high:
  - Start accept edge = cycle 0.
  - Pixel p is valid in cycle 10p+10.
  - done is high in cycle 41.
- Addresses and out_* are outputs of registers or of decode on registered counters; there is no combinational path from out_ready to outputs other than the next-state logic.

Test Plan:
- Image all 1, kernel {1,2,1,0,1,2,1,0,1}, out_ready=1 -> out_pixel=9 at idx 0,1,2,3 in cycles 10,20,30,40; done pulse in cycle 41; busy low from cycle 42.
- Image ramp img[a]=a, same kernel -> idx0=39, idx1=48, idx2=75, idx3=84; img_addr sequence for idx3 = 5,6,7,9,10,11,13,14,15.
- Image all 15, kernel all 15 -> every out_pixel=2025 (0x7E9), no overflow.
- out_ready held low 5 cycles on idx1 -> out_valid stays high, out_pixel=48 and out_idx=1 stable; idx2 follows 10 cycles after acceptance; done delayed by 5 cycles.
- start pulsed again during MAC of idx2 -> ignored; exactly 4 outputs and one done.
- CLR_N asserted mid-MAC of idx1 -> immediate IDLE with all outputs zero; a new start gives the full correct sequence from idx0.
